amplitude_measure_engine: RTL and testbench
===========================================

AMPLITUDE_MEASURE_ENGINE -- requirements
Module: amplitude_measure_engine

Interface
- REQ-001 SHALL have parameter NUM_CH, default 2, meaning number of channels (1..8).
- REQ-002 SHALL have parameter CURSOR_W, default 9, meaning cursor position width.
- REQ-003 SHALL have parameter SCALE_W, default 7, meaning amplitude scale width.
- REQ-004 SHALL have parameter FRAC_SHIFT, default 11, meaning full-scale divisor exponent (divide by 2^FRAC_SHIFT).
- REQ-005 SHALL have parameter SETTLE_CYCLES, default 32, meaning cursor-stable cycles required before conversion.
- REQ-006 SHALL have port Main_CLK, input, width 1: the single clock, rising edge.
- REQ-007 SHALL have port Main_RST_n, input, width 1: reset, asynchronous, active-low.
- REQ-008 SHALL have port Amplitude_Scale, input, width SCALE_W: volts/div scale shared by all channels.
- REQ-009 SHALL have port Up_Cursor, input, width NUM_CH*CURSOR_W: channel k occupies bits [k*CURSOR_W +: CURSOR_W].
- REQ-010 SHALL have port Down_Cursor, input, width NUM_CH*CURSOR_W, packed the same way as Up_Cursor.
- REQ-011 SHALL have port CH_BCD, output, width NUM_CH*24: per channel six BCD digits, 4 integer then 2 fraction (hundredths).
- REQ-012 SHALL have port CH_Valid, output, width NUM_CH: CH_BCD for that channel matches its current cursors.
- REQ-013 SHALL have port Result_Strobe, output, width NUM_CH: one-cycle pulse when a channel's CH_BCD updates.
- REQ-014 SHALL have port Busy, output, width 1: shared converter active.

Function
- REQ-015 SHALL compute per channel V100 = (Amplitude_Scale*|Up-Down|*1000) >> FRAC_SHIFT, truncated, unsigned, with the product held at full width (no overflow).
- REQ-016 SHALL detect a cursor change by comparing against a registered copy each cycle; a change clears CH_Valid[k] next cycle and restarts that channel's settle counter at 0.
- REQ-017 SHALL treat any change of Amplitude_Scale as a change on all channels.
- REQ-018 SHALL raise a conversion request for channel k when its settle counter reaches SETTLE_CYCLES-1 with no change; the counter saturates there.
- REQ-019 SHALL serve requests through a single shared converter with round-robin arbitration starting after the last granted channel; ties after reset start at channel 0.
- REQ-020 SHALL run the converter FSM IDLE -> LOAD (latch operands, 1 cycle) -> MULT (product and shift, 1 cycle) -> DABBLE (serial double-dabble, 16 cycles, one bit per cycle) -> WRITE (1 cycle) -> IDLE, so grant-to-Result_Strobe latency is 19 cycles.
- REQ-021 SHALL, in WRITE, update CH_BCD[k], pulse Result_Strobe[k], and set CH_Valid[k] only if channel k saw no change since LOAD; otherwise keep CH_Valid[k] low and re-arm the settle counter.
- REQ-022 SHALL saturate V100 to 9999.99 (all-9 BCD) when it exceeds 999999.
- REQ-023 SHALL assert Busy in every state except IDLE.
- REQ-024 SHALL produce 0000.00 with CH_Valid high when Up equals Down.

Reset
- REQ-025 SHALL, on Main_RST_n low, immediately clear CH_BCD, CH_Valid, Result_Strobe, and Busy, force the FSM to IDLE, set the round-robin pointer to channel NUM_CH-1, and zero the settle counters.
- REQ-026 SHALL abort any in-flight conversion on reset with no write, and after release convert every channel once it is settled.

Configuration
- REQ-027 SHALL support macro AMPLITUDE_ROUNDING_EN: when defined, add 2^(FRAC_SHIFT-1) before the shift (round half up); when undefined, truncate.

Structure
- REQ-028 SHALL place the FSM state enum, BCD digit count (6), and DABBLE cycle count (16) in package amplitude_pkg.
- REQ-029 SHALL implement the serial converter as sub-module bin_to_bcd_serial (start/done handshake, 16-bit in, 24-bit out).

Verification
- REQ-030 SHALL check: scale=10, Up=300, Down=100 -> CH_BCD=0009.76 (0009.77 with rounding), CH_Valid=1, 19 cycles after grant.
- REQ-031 SHALL check: Up and Down swapped (100/300) -> identical result.
- REQ-032 SHALL check: scale=127, Up=511, Down=0 -> 0316.87 truncated, 0316.88 rounded.
- REQ-033 SHALL check: all NUM_CH channels change in the same cycle -> grants in order 0,1,..., one strobe each, Busy continuous.
- REQ-034 SHALL check: cursor moves during DABBLE -> strobe fires, CH_Valid stays 0, channel reconverts after SETTLE_CYCLES.
- REQ-035 SHALL check: reset asserted mid-DABBLE -> outputs zero immediately, no strobe.

Source files
------------

// File: rtl/amplitude_measure_engine_pkg.sv
// Shared types and constants for the amplitude measurement engine.
package amplitude_pkg;

  // Shared converter sequencing
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MULT,
    ST_DABBLE,
    ST_WRITE
  } conv_state_e;

  localparam int unsigned BCD_DIGITS    = 6;
  localparam int unsigned DABBLE_CYCLES = 16;
  localparam int unsigned BIN_W         = DABBLE_CYCLES;
  localparam int unsigned BCD_W         = 4 * BCD_DIGITS;
  localparam int unsigned DD_W          = BCD_W + BIN_W;

  // One double-dabble iteration on {bcd, bin}: add-3 correction then shift left.
  function automatic logic [DD_W-1:0] dabble_step(input logic [DD_W-1:0] x);
    logic [DD_W-1:0] y;
    y = x;
    for (int d = 0; d < int'(BCD_DIGITS); d++) begin
      if (y[BIN_W + 4*d +: 4] >= 4'd5) y[BIN_W + 4*d +: 4] = y[BIN_W + 4*d +: 4] + 4'd3;
    end
    return {y[DD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/amplitude_measure_engine_bcd.sv
// Serial 16-bit binary to 6-digit BCD converter, one bit per clock.
// The first bit is consumed on the start edge, so done rises 15 cycles later.
module bin_to_bcd_serial
  import amplitude_pkg::*;
(
  input  logic             Main_CLK,
  input  logic             Main_RST_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  localparam int unsigned CNT_W = $clog2(DABBLE_CYCLES);

  logic [DD_W-1:0]  shift_q;
  logic [CNT_W-1:0] left_q;

  // Shift/correct one bit per cycle; done holds until the next start
  always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
    if (!Main_RST_n) begin
      shift_q <= '0;
      left_q  <= '0;
      done    <= 1'b0;
    end else if (start) begin
      shift_q <= dabble_step({BCD_W'(0), bin_in});
      left_q  <= CNT_W'(DABBLE_CYCLES - 1);
      done    <= 1'b0;
    end else if (left_q != '0) begin
      shift_q <= dabble_step(shift_q);
      left_q  <= left_q - CNT_W'(1);
      done    <= (left_q == CNT_W'(1));
    end
  end

  assign bcd_out = shift_q[DD_W-1 -: BCD_W];

endmodule

// File: rtl/amplitude_measure_engine.sv
// Multi-channel cursor amplitude readout: settles each channel's cursors,
// arbitrates a shared multiply + serial BCD converter, and publishes BCD.
// Build option: define AMPLITUDE_ROUNDING_EN to round half up instead of truncating.
module amplitude_measure_engine
  import amplitude_pkg::*;
#(
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned CURSOR_W      = 9,
  parameter int unsigned SCALE_W       = 7,
  parameter int unsigned FRAC_SHIFT    = 11,
  parameter int unsigned SETTLE_CYCLES = 32
) (
  input  logic                         Main_CLK,
  input  logic                         Main_RST_n,
  input  logic [SCALE_W-1:0]           Amplitude_Scale,
  input  logic [NUM_CH*CURSOR_W-1:0]   Up_Cursor,
  input  logic [NUM_CH*CURSOR_W-1:0]   Down_Cursor,
  output logic [NUM_CH*BCD_W-1:0]      CH_BCD,
  output logic [NUM_CH-1:0]            CH_Valid,
  output logic [NUM_CH-1:0]            Result_Strobe,
  output logic                         Busy
);

  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SET_W     = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned PROD_W    = SCALE_W + CURSOR_W + 10;
  localparam int unsigned SUM_W     = PROD_W + 1;
  localparam int unsigned V100_MAX  = 999999;
  localparam int unsigned BIN_MAX   = (1 << BIN_W) - 1;
  localparam logic [SET_W-1:0] SETTLE_MAX = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [BCD_W-1:0] ALL_NINES  = {BCD_DIGITS{4'h9}};
`ifdef AMPLITUDE_ROUNDING_EN
  localparam logic [SUM_W-1:0] ROUND_ADD = SUM_W'(1) << (FRAC_SHIFT - 1);
`else
  localparam logic [SUM_W-1:0] ROUND_ADD = '0;
`endif

  conv_state_e state_q, state_d;

  logic [SCALE_W-1:0]         scale_q;
  logic [NUM_CH*CURSOR_W-1:0] up_q, down_q;
  logic [NUM_CH-1:0]          chg_c, req_c;
  logic [CH_W-1:0]            rr_ptr_q, cur_ch_q, grant_ch_c;
  logic                       grant_c, start_c, dirty_q, sat_q, cur_chg_c;
  logic [CURSOR_W-1:0]        cur_up_c, cur_dn_c, diff_op_q;
  logic [SCALE_W-1:0]         scale_op_q;
  logic [PROD_W-1:0]          prod_c;
  logic [SUM_W-1:0]           sum_c, v100_c;
  logic                       sat_c, cvt_done;
  logic [BIN_W-1:0]           cvt_bin_c;
  logic [BCD_W-1:0]           cvt_bcd;

  // Per-channel change detection, settle counting and request generation
  for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
    logic [SET_W-1:0] settle_q;
    logic             armed_q;

    assign chg_c[k] = (Up_Cursor[k*CURSOR_W +: CURSOR_W]   != up_q[k*CURSOR_W +: CURSOR_W])   ||
                      (Down_Cursor[k*CURSOR_W +: CURSOR_W] != down_q[k*CURSOR_W +: CURSOR_W]) ||
                      (Amplitude_Scale != scale_q);
    assign req_c[k] = armed_q && (settle_q == SETTLE_MAX) && !chg_c[k];

    // Restart on change; armed means a conversion is still owed to this channel
    always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
      if (!Main_RST_n) begin
        settle_q <= '0;
        armed_q  <= 1'b1;
      end else if (chg_c[k]) begin
        settle_q <= '0;
        armed_q  <= 1'b1;
      end else begin
        if (settle_q != SETTLE_MAX) settle_q <= settle_q + SET_W'(1);
        if (grant_c && (grant_ch_c == CH_W'(k))) armed_q <= 1'b0;
      end
    end
  end

  // Round-robin pick, searching from the channel after the last grant
  always_comb begin
    int  idx;
    logic found;
    idx        = 0;
    found      = 1'b0;
    grant_ch_c = rr_ptr_q;
    for (int i = 1; i <= int'(NUM_CH); i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
      if (!found && req_c[CH_W'(idx)]) begin
        found      = 1'b1;
        grant_ch_c = CH_W'(idx);
      end
    end
  end

  // Select the in-flight channel's registered cursors and change flag
  always_comb begin
    cur_chg_c = 1'b0;
    cur_up_c  = '0;
    cur_dn_c  = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (cur_ch_q == CH_W'(k)) begin
        cur_chg_c = chg_c[k];
        cur_up_c  = up_q[k*CURSOR_W +: CURSOR_W];
        cur_dn_c  = down_q[k*CURSOR_W +: CURSOR_W];
      end
    end
  end

  // Full-width scaled product, optional rounding, and range clamp
  always_comb begin
    prod_c    = PROD_W'(scale_op_q) * PROD_W'(diff_op_q) * PROD_W'(1000);
    sum_c     = SUM_W'(prod_c) + ROUND_ADD;
    v100_c    = sum_c >> FRAC_SHIFT;
    // anything the 16-bit converter cannot represent also clamps to all nines
    sat_c     = (v100_c > SUM_W'(V100_MAX)) || (v100_c > SUM_W'(BIN_MAX));
    cvt_bin_c = BIN_W'(v100_c);
  end

  // Converter state register
  always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
    if (!Main_RST_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next state; WRITE grants directly so back-to-back channels keep Busy high
  always_comb begin
    state_d = state_q;
    grant_c = 1'b0;
    start_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_c) begin
          grant_c = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:   state_d = ST_MULT;
      ST_MULT: begin
        start_c = 1'b1;
        state_d = ST_DABBLE;
      end
      ST_DABBLE: if (cvt_done) state_d = ST_WRITE;
      ST_WRITE: begin
        if (|req_c) begin
          grant_c = 1'b1;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // Input history, operand capture, result publishing and arbitration pointer
  always_ff @(posedge Main_CLK or negedge Main_RST_n) begin
    if (!Main_RST_n) begin
      scale_q       <= '0;
      up_q          <= '0;
      down_q        <= '0;
      rr_ptr_q      <= CH_W'(NUM_CH - 1);
      cur_ch_q      <= '0;
      dirty_q       <= 1'b0;
      scale_op_q    <= '0;
      diff_op_q     <= '0;
      sat_q         <= 1'b0;
      CH_BCD        <= '0;
      CH_Valid      <= '0;
      Result_Strobe <= '0;
      Busy          <= 1'b0;
    end else begin
      scale_q       <= Amplitude_Scale;
      up_q          <= Up_Cursor;
      down_q        <= Down_Cursor;
      Busy          <= (state_d != ST_IDLE);
      Result_Strobe <= '0;
      CH_Valid      <= CH_Valid & ~chg_c;
      if ((state_q != ST_IDLE) && cur_chg_c) dirty_q <= 1'b1;
      if (state_q == ST_LOAD) begin
        scale_op_q <= scale_q;
        diff_op_q  <= (cur_up_c >= cur_dn_c) ? (cur_up_c - cur_dn_c) : (cur_dn_c - cur_up_c);
      end
      if (state_q == ST_MULT) sat_q <= sat_c;
      if (state_q == ST_WRITE) begin
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (cur_ch_q == CH_W'(k)) begin
            CH_BCD[k*BCD_W +: BCD_W] <= sat_q ? ALL_NINES : cvt_bcd;
            Result_Strobe[k]         <= 1'b1;
            if (!dirty_q && !chg_c[k]) CH_Valid[k] <= 1'b1;
          end
        end
      end
      if (grant_c) begin
        rr_ptr_q <= grant_ch_c;
        cur_ch_q <= grant_ch_c;
        dirty_q  <= 1'b0;
      end
    end
  end

  bin_to_bcd_serial u_bcd (
    .Main_CLK   (Main_CLK),
    .Main_RST_n (Main_RST_n),
    .start      (start_c),
    .bin_in     (cvt_bin_c),
    .done       (cvt_done),
    .bcd_out    (cvt_bcd)
  );

endmodule

// File: tb/tb_amplitude_measure_engine.sv
// Directed bench for amplitude_measure_engine (two channels, default parameters).
// Expected BCD values are hand-computed; AMPLITUDE_ROUNDING_EN selects the rounded set.
module tb_amplitude_measure_engine;

  logic        Main_CLK = 1'b0;
  logic        Main_RST_n;
  logic [6:0]  Amplitude_Scale;
  logic [17:0] Up_Cursor;
  logic [17:0] Down_Cursor;
  logic [47:0] CH_BCD;
  logic [1:0]  CH_Valid;
  logic [1:0]  Result_Strobe;
  logic        Busy;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef AMPLITUDE_ROUNDING_EN
  localparam logic [23:0] E976   = 24'h000977;
  localparam logic [23:0] E31687 = 24'h031688;
  localparam logic [23:0] E249   = 24'h000250;
  localparam logic [23:0] E14    = 24'h000015;
`else
  localparam logic [23:0] E976   = 24'h000976;
  localparam logic [23:0] E31687 = 24'h031687;
  localparam logic [23:0] E249   = 24'h000249;
  localparam logic [23:0] E14    = 24'h000014;
`endif

  amplitude_measure_engine dut (
    .Main_CLK        (Main_CLK),
    .Main_RST_n      (Main_RST_n),
    .Amplitude_Scale (Amplitude_Scale),
    .Up_Cursor       (Up_Cursor),
    .Down_Cursor     (Down_Cursor),
    .CH_BCD          (CH_BCD),
    .CH_Valid        (CH_Valid),
    .Result_Strobe   (Result_Strobe),
    .Busy            (Busy)
  );

  always #5 Main_CLK = ~Main_CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (!Busy && n < 200) begin
      @(negedge Main_CLK);
      n++;
    end
    check_eq({tag, "_busy_rise"}, 32'(Busy), 32'd1);
  endtask

  // Apply one vector to both channels and check order, latency, Busy and results
  task automatic run_pair(input string tag, input logic [6:0] sc,
                          input logic [8:0] u0, input logic [8:0] d0,
                          input logic [8:0] u1, input logic [8:0] d1,
                          input logic [23:0] e0, input logic [23:0] e1);
    int t0, t1, s0;
    logic drop;
    @(negedge Main_CLK);
    Amplitude_Scale = sc;
    Up_Cursor       = {u1, u0};
    Down_Cursor     = {d1, d0};
    wait_busy(tag);
    t0 = 0; t1 = 0; s0 = 0; drop = 1'b0;
    for (int c = 1; c <= 80 && t1 == 0; c++) begin
      @(negedge Main_CLK);
      if (Result_Strobe[0]) begin
        s0++;
        if (t0 == 0) begin
          t0 = c;
          check_eq({tag, "_bcd0"},   32'(CH_BCD[23:0]), 32'(e0));
          check_eq({tag, "_valid0"}, 32'(CH_Valid[0]),  32'd1);
        end
      end
      if (Result_Strobe[1]) begin
        t1 = c;
        check_eq({tag, "_bcd1"},   32'(CH_BCD[47:24]), 32'(e1));
        check_eq({tag, "_valid1"}, 32'(CH_Valid[1]),   32'd1);
      end else if (!Busy) begin
        drop = 1'b1;
      end
    end
    check_eq({tag, "_lat0"},      32'(t0),   32'd19);
    check_eq({tag, "_lat1"},      32'(t1),   32'd38);
    check_eq({tag, "_strobes0"},  32'(s0),   32'd1);
    check_eq({tag, "_busy_cont"}, 32'(drop), 32'd0);
  endtask

  initial begin
    int t0a, t0b, t1;
    logic seen;
    Main_RST_n      = 1'b0;
    Amplitude_Scale = '0;
    Up_Cursor       = '0;
    Down_Cursor     = '0;
    repeat (3) @(negedge Main_CLK);
    check_eq("rst_bcd",    32'(CH_BCD[31:0]),  32'd0);
    check_eq("rst_valid",  32'(CH_Valid),      32'd0);
    check_eq("rst_strobe", 32'(Result_Strobe), 32'd0);
    check_eq("rst_busy",   32'(Busy),          32'd0);
    Main_RST_n = 1'b1;

    run_pair("post_reset", 7'd0,   9'd0,   9'd0,   9'd0,   9'd0,   24'h000000, 24'h000000);
    run_pair("scale10",    7'd10,  9'd300, 9'd100, 9'd100, 9'd300, E976, E976);
    run_pair("scale127",   7'd127, 9'd511, 9'd0,   9'd5,   9'd5,   E31687, 24'h000000);
    run_pair("scale64",    7'd64,  9'd0,   9'd256, 9'd256, 9'd0,   24'h008000, 24'h008000);
    run_pair("scale1",     7'd1,   9'd511, 9'd0,   9'd2,   9'd7,   E249, 24'h000002);

    // Cursor moves while channel 0 is in DABBLE
    @(negedge Main_CLK);
    Amplitude_Scale = 7'd3;
    Up_Cursor       = {9'd2, 9'd7};
    Down_Cursor     = {9'd7, 9'd2};
    wait_busy("move");
    repeat (8) @(negedge Main_CLK);
    Up_Cursor[8:0] = 9'd12;
    t0a = 0; t0b = 0; t1 = 0;
    for (int c = 1; c <= 120 && t0b == 0; c++) begin
      @(negedge Main_CLK);
      if (Result_Strobe[0]) begin
        if (t0a == 0) begin
          t0a = c;
          check_eq("move_stale_valid0", 32'(CH_Valid[0]),  32'd0);
          check_eq("move_stale_bcd0",   32'(CH_BCD[23:0]), 32'h7);
        end else begin
          t0b = c;
          check_eq("move_redo_valid0", 32'(CH_Valid[0]),  32'd1);
          check_eq("move_redo_bcd0",   32'(CH_BCD[23:0]), 32'(E14));
        end
      end
      if (Result_Strobe[1]) begin
        t1 = c;
        check_eq("move_valid1", 32'(CH_Valid[1]),   32'd1);
        check_eq("move_bcd1",   32'(CH_BCD[47:24]), 32'h7);
      end
    end
    check_eq("move_t_stale0", 32'(t0a), 32'd11);
    check_eq("move_t_ch1",    32'(t1),  32'd30);
    check_eq("move_t_redo0",  32'(t0b), 32'd52);

    // Reset in the middle of DABBLE aborts without a write
    @(negedge Main_CLK);
    Amplitude_Scale = 7'd5;
    Up_Cursor       = {9'd0, 9'd100};
    Down_Cursor     = {9'd100, 9'd0};
    wait_busy("abort");
    repeat (6) @(negedge Main_CLK);
    Main_RST_n = 1'b0;
    #1;
    check_eq("abort_bcd",    32'(CH_BCD[31:0]),  32'd0);
    check_eq("abort_bcd_hi", 32'(CH_BCD[47:32]), 32'd0);
    check_eq("abort_valid",  32'(CH_Valid),      32'd0);
    check_eq("abort_busy",   32'(Busy),          32'd0);
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge Main_CLK);
      if (Result_Strobe != 2'b00) seen = 1'b1;
    end
    check_eq("abort_no_strobe", 32'(seen), 32'd0);
    Main_RST_n = 1'b1;
    run_pair("after_abort", 7'd5, 9'd100, 9'd0, 9'd0, 9'd100, 24'h000244, 24'h000244);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
